// File: rtl/filter_test_sequencer_pkg.sv
// Shared types and default sizing for the filter test sequencer.
//   seq_state_t  sequencer FSM encoding
//   test_cfg_t   one stimulus table entry {overlay, rate, delay}
package filter_test_sequencer_pkg;

  localparam int SIZE_DELAY            = 8;
  localparam int SIZE_FILTER_DATA      = 16;
  localparam int NUM_CASES_DEFAULT     = 4;
  localparam int SETTLE_CYCLES_DEFAULT = 16;
  localparam int DWELL_CYCLES_DEFAULT  = 1024;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    REPORT,
    FINISH
  } seq_state_t;

  typedef struct packed {
    logic                  overlay;
    logic                  rate;
    logic [SIZE_DELAY-1:0] delay;
  } test_cfg_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/filter_test_sequencer_peak.sv
// Signed running-maximum register used during the dwell window.
//   clk, reset  clock, async active-low reset
//   clear       force peak to 0 (highest priority after reset)
//   load        take data unconditionally (first sample of a window)
//   enable      take data only if strictly greater than current peak
//   data        signed sample
//   peak        signed running maximum
module seq_peak_detector #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                load,
  input  logic                enable,
  input  logic signed [W-1:0] data,
  output logic signed [W-1:0] peak
);

  logic signed [W-1:0] peak_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else if (clear) begin
      peak_q <= '0;
    end else if (load) begin
      peak_q <= data;
    end else if (enable && (data > peak_q)) begin
      peak_q <= data;
    end
  end

  assign peak = peak_q;

endmodule

// File: rtl/filter_test_sequencer.sv
// Steps exp_sig_gen through a table of stimulus settings, waits for the filter
// chain to settle, tracks the signed peak of one filter output over a dwell
// window and hands each per-case result out on a valid/ready port.
//   clk, reset                 clock, async active-low reset
//   start, abort               run control
//   cfg_we/cfg_addr/cfg_data   stimulus table write port (IDLE only)
//   filter_data                signed filter output under test
//   test_overlay/rate/delay    drive exp_sig_gen
//   busy                       high outside IDLE
//   result_valid/ready/case/peak  per-case result handshake
//   done                       one-cycle pulse after last result accepted
//
// state   | meaning
// IDLE    | table writable, waiting for start, test_* held at 0
// SETTLE  | new stimulus applied, filter_data ignored
// MEASURE | peak tracking over the dwell window
// REPORT  | result presented until accepted
// FINISH  | done pulse, back to IDLE
module filter_test_sequencer
  import filter_test_sequencer_pkg::*;
#(
  parameter int NUM_CASES     = NUM_CASES_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int DWELL_CYCLES  = DWELL_CYCLES_DEFAULT,
  localparam int CASE_W = $clog2(NUM_CASES),
  localparam int CFG_W  = $bits(test_cfg_t),
  localparam int CNT_W  = $clog2(max_int(SETTLE_CYCLES, DWELL_CYCLES) + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        cfg_we,
  input  logic [CASE_W-1:0]           cfg_addr,
  input  logic [CFG_W-1:0]            cfg_data,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  output logic                        test_overlay,
  output logic                        test_rate,
  output logic [SIZE_DELAY-1:0]       test_delay,
  output logic                        busy,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [CASE_W-1:0]           result_case,
  output logic [SIZE_FILTER_DATA-1:0] result_peak,
  output logic                        done
);

  seq_state_t                   state, state_next;
  logic [CNT_W-1:0]             cnt;
  logic [CASE_W-1:0]            case_idx, case_next;
  test_cfg_t                    cfg_table [NUM_CASES];
  test_cfg_t                    cfg_q, cfg_sel;
  logic                         last_case, entering_settle, entering_measure;
  logic                         peak_clear, peak_load, peak_en;
  logic signed [SIZE_FILTER_DATA-1:0] peak;

  assign last_case        = (case_idx == CASE_W'(NUM_CASES - 1));
  assign case_next        = (state == IDLE) ? '0 : case_idx + CASE_W'(1);
  assign entering_settle  = (state_next == SETTLE)  && (state != SETTLE);
  assign entering_measure = (state_next == MEASURE) && (state != MEASURE);

  // A write landing in the same cycle as start must reach the first case.
  always_comb begin
    cfg_sel = cfg_table[case_next];
    if ((state == IDLE) && cfg_we && (cfg_addr == case_next))
      cfg_sel = test_cfg_t'(cfg_data);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CASES; i++) cfg_table[i] <= '0;
    end else if ((state == IDLE) && cfg_we) begin
      cfg_table[cfg_addr] <= test_cfg_t'(cfg_data);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (cnt == '0) state_next = MEASURE;
      MEASURE: if (cnt == '0) state_next = REPORT;
      REPORT:  if (result_ready) state_next = last_case ? FINISH : SETTLE;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      case_idx <= '0;
      cfg_q    <= '0;
    end else begin
      if (entering_settle)       cnt <= CNT_W'(SETTLE_CYCLES - 1);
      else if (entering_measure) cnt <= CNT_W'(DWELL_CYCLES - 1);
      else if (cnt != '0)        cnt <= cnt - CNT_W'(1);

      if (state_next == IDLE) begin
        case_idx <= '0;
        cfg_q    <= '0;
      end else if (entering_settle) begin
        case_idx <= case_next;
        cfg_q    <= cfg_sel;
      end
    end
  end

  // The counter starts the dwell at DWELL_CYCLES-1, so that value marks the first sample.
  assign peak_clear = (state == IDLE);
  assign peak_load  = (state == MEASURE) && (cnt == CNT_W'(DWELL_CYCLES - 1));
  assign peak_en    = (state == MEASURE);

  seq_peak_detector #(.W(SIZE_FILTER_DATA)) u_peak (
    .clk    (clk),
    .reset  (reset),
    .clear  (peak_clear),
    .load   (peak_load),
    .enable (peak_en),
    .data   (filter_data),
    .peak   (peak)
  );

  always_comb begin
    test_overlay = cfg_q.overlay;
    test_rate    = cfg_q.rate;
    test_delay   = cfg_q.delay;
    busy         = (state != IDLE);
    result_valid = (state == REPORT);
    done         = (state == FINISH);
    result_case  = case_idx;
    result_peak  = peak;
  end

endmodule
